// File: rtl/alu_ctrl_pipe.sv
// ALU-control decode stage between ID and EX. It uses a valid/ready handshake and holds
// divide/remainder ops for DIV_LAT cycles to model an iterative divider.
module alu_ctrl_pipe #(
  parameter int ALU_OP_W = 5,
  parameter int ENABLE_M = 1,
  parameter int DIV_LAT  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          op,
  input  logic [2:0]          f3,
  input  logic [6:0]          f7,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic                busy
);

  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam bit MULTI = (DIV_LAT > 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  localparam logic [4:0] A_ADD  = 5'd0;
  localparam logic [4:0] A_SUB  = 5'd1;
  localparam logic [4:0] A_SLL  = 5'd2;
  localparam logic [4:0] A_SLT  = 5'd3;
  localparam logic [4:0] A_SLTU = 5'd4;
  localparam logic [4:0] A_XOR  = 5'd5;
  localparam logic [4:0] A_SRL  = 5'd6;
  localparam logic [4:0] A_SRA  = 5'd7;
  localparam logic [4:0] A_OR   = 5'd8;
  localparam logic [4:0] A_AND  = 5'd9;
  localparam logic [4:0] A_MUL  = 5'd10;
  localparam logic [4:0] A_PASS = 5'd18;

  function automatic logic [4:0] base_op(input logic [2:0] fn3);
    logic [4:0] r;
    case (fn3)
      3'b000:  r = A_ADD;
      3'b001:  r = A_SLL;
      3'b010:  r = A_SLT;
      3'b011:  r = A_SLTU;
      3'b100:  r = A_XOR;
      3'b101:  r = A_SRL;
      3'b110:  r = A_OR;
      default: r = A_AND;
    endcase
    return r;
  endfunction

  // Returns {illegal, code}; illegal combinations always report ADD.
  function automatic logic [5:0] decode(input logic [6:0] opc, input logic [2:0] fn3,
                                        input logic [6:0] fn7);
    logic       ill;
    logic [4:0] code;
    ill  = 1'b0;
    code = A_ADD;
    case (opc)
      OP_R: begin
        if (fn7 == F7_BASE) code = base_op(fn3);
        else if (fn7 == F7_ALT && fn3 == 3'b000) code = A_SUB;
        else if (fn7 == F7_ALT && fn3 == 3'b101) code = A_SRA;
        else if (fn7 == F7_M && ENABLE_M != 0) code = A_MUL + {2'b00, fn3};
        else ill = 1'b1;
      end
      OP_I: begin
        if (fn3 == 3'b001) begin
          if (fn7 == F7_BASE) code = A_SLL;
          else ill = 1'b1;
        end else if (fn3 == 3'b101) begin
          if (fn7 == F7_BASE) code = A_SRL;
          else if (fn7 == F7_ALT) code = A_SRA;
          else ill = 1'b1;
        end else begin
          code = base_op(fn3);
        end
      end
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_AUIPC: code = A_ADD;
      OP_BRANCH: code = A_SUB;
      OP_LUI:    code = A_PASS;
      default:   ill = 1'b1;
    endcase
    if (ill) code = A_ADD;
    return {ill, code};
  endfunction

  logic [5:0]          dec_p0;
  logic                div_p0;
  logic                accept_p0;
  logic [ALU_OP_W-1:0] alu_op_p1;
  logic                illegal_p1;
  logic                vld_p1;
  logic                busy_p1;
  logic [CNT_W-1:0]    cnt_p1;

  assign dec_p0    = decode(op, f3, f7);
  assign div_p0    = MULTI && (ENABLE_M != 0) && op == OP_R && f7 == F7_M && f3[2];
  assign in_ready  = !busy_p1 && !flush && (!vld_p1 || out_ready);
  assign accept_p0 = in_valid && in_ready;

  // p0 -> p1: decode register plus divider-latency countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      busy_p1    <= 1'b0;
      cnt_p1     <= '0;
      alu_op_p1  <= '0;
      illegal_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      busy_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else if (accept_p0) begin
      alu_op_p1  <= ALU_OP_W'(dec_p0[4:0]);
      illegal_p1 <= dec_p0[5];
      if (div_p0) begin
        busy_p1 <= 1'b1;
        cnt_p1  <= CNT_W'(DIV_LAT - 1);
        vld_p1  <= 1'b0;
      end else begin
        vld_p1 <= 1'b1;
      end
    end else if (busy_p1) begin
      // A zero count means the final hold cycle has elapsed.
      if (cnt_p1 == '0) begin
        busy_p1 <= 1'b0;
        vld_p1  <= 1'b1;
      end else begin
        cnt_p1 <= cnt_p1 - 1'b1;
      end
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign alu_op    = alu_op_p1;
  assign illegal   = illegal_p1;
  assign busy      = busy_p1;

endmodule
